move_scheduler: RTL
===================

// Module: move_scheduler
// PURPOSE
//  Per-frame movement controller for the maze game. Gates single-pixel steps for the player and ghost
//  position datapaths via fractional speed accumulators. Sequences game state READY/RUN/DYING/CLEAR
//  and the ghost SCATTER/CHASE/FRIGHT schedule. Sits between game logic (pellet/collision events) and
//  the player/ghost movers; each mover advances one pixel only in frames where its step bit is high.
// PARAMETERS
//  N_GHOST        4     number of ghost movers
//  PLAYER_SPD     205   player speed, steps per 256 frames (8 bit)
//  GHOST_SPD      192   ghost speed in SCATTER/CHASE
//  FRIGHT_SPD     128   ghost speed in FRIGHT
//  TUNNEL_SPD     100   ghost speed while ghost_tunnel[i]=1 (overrides other ghost speeds)
//  READY_FRAMES   120   READY hold time (frames)
//  SCATTER_FRAMES 420   scatter phase length
//  CHASE_FRAMES   1200  chase phase length
//  FRIGHT_FRAMES  360   fright duration
//  DYING_FRAMES   90    death animation hold
//  N_PHASES       4     scatter/chase phases before permanent CHASE
// PORTS
//  frame_clk     in   1        frame clock (one edge per video frame)
//  Reset         in   1        async active-high reset
//  start         in   1        level pulse; leave IDLE/CLEAR
//  power_pellet  in   1        power pellet eaten this frame
//  player_caught in   1        player/ghost collision this frame
//  level_clear   in   1        last pellet eaten this frame
//  ghost_tunnel  in   N_GHOST  ghost i inside side tunnel row
//  keycode       in   8        keyboard keycode (used only under PAUSE_KEY_EN)
//  player_step   out  1        player may move 1 px this frame
//  ghost_step    out  N_GHOST  ghost i may move 1 px this frame
//  ghost_reverse out  1        one-frame pulse: all ghosts reverse direction
//  ghost_mode    out  2        0=SCATTER 1=CHASE 2=FRIGHT
//  game_state    out  3        0=IDLE 1=READY 2=RUN 3=DYING 4=CLEAR 5=PAUSED
// BEHAVIOUR
//  - Reset: game_state=IDLE, ghost_mode=SCATTER, all steps/reverse 0, accumulators 0, timers 0, phase 0.
//  - Reset mid-game returns to exactly the reset values on assertion (async), regardless of state.
//  - All outputs registered. An input sampled at edge k affects outputs after edge k.
//  - IDLE --start--> READY (timer=READY_FRAMES). READY: count down; at 0 -> RUN, SCATTER, phase 0.
//  - RUN: per entity acc <= acc + spd (9-bit sum); step = sum[8]; acc keeps sum[7:0]. Outside RUN: steps 0, acc held.
//  - Phase timer runs only while ghost_mode!=FRIGHT. At expiry: toggle SCATTER<->CHASE, phase++,
//    pulse ghost_reverse. Once phase==N_PHASES-1, enter CHASE and never toggle again.
//  - power_pellet in RUN: ghost_mode=FRIGHT, fright timer=FRIGHT_FRAMES, ghost_reverse pulse.
//    Repeated while FRIGHT reloads timer, no reverse pulse.
//  - Fright timer expiry restores the saved SCATTER/CHASE mode; phase timer resumes from its held value.
//  - player_caught in RUN -> DYING (timer=DYING_FRAMES); at 0 -> READY; phase/mode reset to SCATTER phase 0.
//  - level_clear in RUN -> CLEAR; CLEAR --start--> READY with accumulators cleared.
//  - Same-frame priority: level_clear > player_caught > power_pellet. Loser events are dropped.
//  - Inputs outside RUN (except start) are ignored. start outside IDLE/CLEAR is ignored.
//  - Timers are 11 bit, load N then count to 0: state lasts exactly N frames.
// CONFIGURATION
//  PAUSE_KEY_EN defined: rising edge of (keycode==8'h13) in RUN -> PAUSED (steps 0, all timers and
//  accumulators frozen). Next rising edge returns to RUN with no state loss. Edge detector resets to 0.
//  Undefined: keycode ignored, PAUSED unreachable.
// STRUCTURE
//  Package move_sched_pkg: game_state_t, ghost_mode_t enums; default speed and frame-count localparams.
//  Sub-module speed_accum (spd, en, step): one per entity, instantiated N_GHOST+1 times via generate.
// TESTING
//  1 Reset, start pulse -> game_state READY for 120 frames, then RUN, ghost_mode=SCATTER.
//  2 RUN 256 frames, no tunnel -> player_step count 205, each ghost_step count 192.
//  3 Frame 420 of RUN -> ghost_mode CHASE plus one-frame ghost_reverse. After 4 phases -> permanent CHASE.
//  4 power_pellet at scatter frame 100 -> FRIGHT 360 frames, ghost steps 128/256.
//    Then SCATTER resumes, expiring 320 frames later.
//  5 power_pellet, player_caught, level_clear in the same frame -> CLEAR, ghost_mode unchanged.
//  6 PAUSE_KEY_EN: keycode 8'h13 held 10 frames -> single PAUSED entry, zero steps.
//    Second press -> RUN, accumulator values identical.

Source files
------------

// File: rtl/move_sched_pkg.sv
// Shared types and default tuning for the maze-game movement scheduler.
// Latency: none (types and constants only).
// Backpressure: none.
package move_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DYING  = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_PAUSED = 3'd5
    } game_state_t;

    typedef enum logic [1:0] {
        GM_SCATTER = 2'd0,
        GM_CHASE   = 2'd1,
        GM_FRIGHT  = 2'd2
    } ghost_mode_t;

    localparam int DEF_N_GHOST        = 4;
    localparam int DEF_PLAYER_SPD     = 205;
    localparam int DEF_GHOST_SPD      = 192;
    localparam int DEF_FRIGHT_SPD     = 128;
    localparam int DEF_TUNNEL_SPD     = 100;
    localparam int DEF_READY_FRAMES   = 120;
    localparam int DEF_SCATTER_FRAMES = 420;
    localparam int DEF_CHASE_FRAMES   = 1200;
    localparam int DEF_FRIGHT_FRAMES  = 360;
    localparam int DEF_DYING_FRAMES   = 90;
    localparam int DEF_N_PHASES       = 4;

    localparam int          TMR_W     = 11;
    localparam logic [7:0]  PAUSE_KEY = 8'h13;

endpackage

// File: rtl/move_scheduler_if.sv
// Game-logic <-> scheduler bundle: frame events in, per-mover step bits and mode/state out.
// Latency: none (wiring only).
// Backpressure: none; every field is a per-frame level.
interface move_scheduler_if #(
    parameter int N_GHOST = 4
);
    import move_sched_pkg::*;

    logic               start;
    logic               power_pellet;
    logic               player_caught;
    logic               level_clear;
    logic [N_GHOST-1:0] ghost_tunnel;
    logic [7:0]         keycode;
    logic               player_step;
    logic [N_GHOST-1:0] ghost_step;
    logic               ghost_reverse;
    ghost_mode_t        ghost_mode;
    game_state_t        game_state;

    modport master (
        output start, power_pellet, player_caught, level_clear, ghost_tunnel, keycode,
        input  player_step, ghost_step, ghost_reverse, ghost_mode, game_state
    );

    modport slave (
        input  start, power_pellet, player_caught, level_clear, ghost_tunnel, keycode,
        output player_step, ghost_step, ghost_reverse, ghost_mode, game_state
    );

endinterface

// File: rtl/speed_accum.sv
// Fractional speed accumulator: emits one step per 256/spd enabled frames on average.
// Latency: step registered one frame edge after the enabled add.
// Backpressure: none; en=0 holds the accumulator and forces step low.
module speed_accum (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] spd,
    output logic       step
);

    logic [7:0] acc;
    logic [8:0] sum;

    assign sum = {1'b0, acc} + {1'b0, spd};

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            acc  <= 8'd0;
            step <= 1'b0;
        end else if (clr) begin
            acc  <= 8'd0;
            step <= 1'b0;
        end else if (en) begin
            acc  <= sum[7:0];
            step <= sum[8];
        end else begin
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Per-frame movement scheduler: speed-gated step bits, game state sequencing, ghost mode schedule.
// Latency: inputs sampled at a frame edge appear on the registered outputs right after that edge.
// Backpressure: none; with PAUSE_KEY_EN defined, keycode 8'h13 edges toggle a freeze of all timers/accumulators.
module move_scheduler
    import move_sched_pkg::*;
#(
    parameter int N_GHOST        = DEF_N_GHOST,
    parameter int PLAYER_SPD     = DEF_PLAYER_SPD,
    parameter int GHOST_SPD      = DEF_GHOST_SPD,
    parameter int FRIGHT_SPD     = DEF_FRIGHT_SPD,
    parameter int TUNNEL_SPD     = DEF_TUNNEL_SPD,
    parameter int READY_FRAMES   = DEF_READY_FRAMES,
    parameter int SCATTER_FRAMES = DEF_SCATTER_FRAMES,
    parameter int CHASE_FRAMES   = DEF_CHASE_FRAMES,
    parameter int FRIGHT_FRAMES  = DEF_FRIGHT_FRAMES,
    parameter int DYING_FRAMES   = DEF_DYING_FRAMES,
    parameter int N_PHASES       = DEF_N_PHASES
) (
    input  logic              frame_clk,
    input  logic              Reset,
    move_scheduler_if.slave   bus
);

    localparam logic [7:0]       P_SPD     = 8'(PLAYER_SPD);
    localparam logic [7:0]       G_SPD     = 8'(GHOST_SPD);
    localparam logic [7:0]       F_SPD     = 8'(FRIGHT_SPD);
    localparam logic [7:0]       T_SPD     = 8'(TUNNEL_SPD);
    localparam logic [TMR_W-1:0] T_READY   = TMR_W'(READY_FRAMES);
    localparam logic [TMR_W-1:0] T_SCATTER = TMR_W'(SCATTER_FRAMES);
    localparam logic [TMR_W-1:0] T_CHASE   = TMR_W'(CHASE_FRAMES);
    localparam logic [TMR_W-1:0] T_FRIGHT  = TMR_W'(FRIGHT_FRAMES);
    localparam logic [TMR_W-1:0] T_DYING   = TMR_W'(DYING_FRAMES);
    localparam logic [TMR_W-1:0] T_ONE     = TMR_W'(1);
    localparam int               PH_W      = $clog2(N_PHASES + 1);
    localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(N_PHASES - 1);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);

    game_state_t        state;
    ghost_mode_t        mode;
    ghost_mode_t        base_mode;
    logic [TMR_W-1:0]   st_tmr;
    logic [TMR_W-1:0]   ph_tmr;
    logic [TMR_W-1:0]   fr_tmr;
    logic [PH_W-1:0]    phase;
    logic               rev;
    logic               key_rise;

`ifdef PAUSE_KEY_EN
    logic key_hit;
    logic key_q;

    assign key_hit  = (bus.keycode == PAUSE_KEY);
    assign key_rise = key_hit && !key_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) key_q <= 1'b0;
        else       key_q <= key_hit;
    end
`else
    logic keycode_unused;
    assign keycode_unused = ^bus.keycode;
    assign key_rise       = 1'b0;
`endif

    // stay_run: a RUN frame with no higher-priority exit; only these frames advance movers and timers
    logic in_run;
    logic stay_run;
    logic acc_clr;

    assign in_run   = (state == ST_RUN);
    assign stay_run = in_run && !bus.level_clear && !bus.player_caught && !key_rise;
    assign acc_clr  = (state == ST_CLEAR) && bus.start;

    logic               player_step_w;
    logic [N_GHOST-1:0] ghost_step_w;

    speed_accum u_player_acc (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clr       (acc_clr),
        .en        (stay_run),
        .spd       (P_SPD),
        .step      (player_step_w)
    );

    for (genvar gi = 0; gi < N_GHOST; gi++) begin : g_ghost_acc
        logic [7:0] spd;
        assign spd = bus.ghost_tunnel[gi] ? T_SPD :
                     (mode == GM_FRIGHT)  ? F_SPD : G_SPD;

        speed_accum u_acc (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .clr       (acc_clr),
            .en        (stay_run),
            .spd       (spd),
            .step      (ghost_step_w[gi])
        );
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            mode      <= GM_SCATTER;
            base_mode <= GM_SCATTER;
            st_tmr    <= '0;
            ph_tmr    <= '0;
            fr_tmr    <= '0;
            phase     <= '0;
            rev       <= 1'b0;
        end else begin
            rev <= 1'b0;
            case (state)
                ST_IDLE, ST_CLEAR: begin
                    if (bus.start) begin
                        state  <= ST_READY;
                        st_tmr <= T_READY;
                    end
                end
                ST_READY: begin
                    if (st_tmr <= T_ONE) begin
                        state     <= ST_RUN;
                        st_tmr    <= '0;
                        mode      <= GM_SCATTER;
                        base_mode <= GM_SCATTER;
                        phase     <= '0;
                        ph_tmr    <= T_SCATTER;
                        fr_tmr    <= '0;
                    end else begin
                        st_tmr <= st_tmr - T_ONE;
                    end
                end
                ST_DYING: begin
                    if (st_tmr <= T_ONE) begin
                        state     <= ST_READY;
                        st_tmr    <= T_READY;
                        mode      <= GM_SCATTER;
                        base_mode <= GM_SCATTER;
                        phase     <= '0;
                        fr_tmr    <= '0;
                    end else begin
                        st_tmr <= st_tmr - T_ONE;
                    end
                end
                ST_PAUSED: begin
                    if (key_rise) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.level_clear) begin
                        state <= ST_CLEAR;
                    end else if (bus.player_caught) begin
                        state  <= ST_DYING;
                        st_tmr <= T_DYING;
                    end else if (key_rise) begin
                        state <= ST_PAUSED;
                    end else begin
                        if (mode != GM_FRIGHT && phase != LAST_PH) begin
                            if (ph_tmr <= T_ONE) begin
                                phase <= phase + PH_ONE;
                                rev   <= 1'b1;
                                if ((phase + PH_ONE) == LAST_PH) begin
                                    base_mode <= GM_CHASE;
                                    mode      <= GM_CHASE;
                                    ph_tmr    <= '0;
                                end else if (base_mode == GM_SCATTER) begin
                                    base_mode <= GM_CHASE;
                                    mode      <= GM_CHASE;
                                    ph_tmr    <= T_CHASE;
                                end else begin
                                    base_mode <= GM_SCATTER;
                                    mode      <= GM_SCATTER;
                                    ph_tmr    <= T_SCATTER;
                                end
                            end else begin
                                ph_tmr <= ph_tmr - T_ONE;
                            end
                        end
                        // later assignments win: a pellet overrides a same-frame phase flip of the visible mode
                        if (bus.power_pellet) begin
                            mode   <= GM_FRIGHT;
                            fr_tmr <= T_FRIGHT;
                            if (mode != GM_FRIGHT) rev <= 1'b1;
                        end else if (mode == GM_FRIGHT) begin
                            if (fr_tmr <= T_ONE) begin
                                mode   <= base_mode;
                                fr_tmr <= '0;
                            end else begin
                                fr_tmr <= fr_tmr - T_ONE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.player_step   = player_step_w;
    assign bus.ghost_step    = ghost_step_w;
    assign bus.ghost_reverse = rev;
    assign bus.ghost_mode    = mode;
    assign bus.game_state    = state;

endmodule
